// File: rtl/weighted_vote_tally_if.sv
// Ballot/session bus for weighted_vote_tally: session control and ballots in, tally and status out.
// The master side drives ballots and session control; the slave side is the tally engine.
interface weighted_vote_tally_if #(
    parameter int unsigned NP_W   = 32,
    parameter int unsigned VIP_W  = 8,
    parameter int unsigned VVIP_W = 1,
    parameter int unsigned RES_W  = 16
);
    logic              start;
    logic              close;
    logic              in_valid;
    logic [NP_W-1:0]   np;
    logic [VIP_W-1:0]  vip;
    logic [VVIP_W-1:0] vvip;
    logic              in_ready;
    logic [RES_W-1:0]  result;
    logic [1:0]        state;
    logic              done;
    logic              pass;
    logic              overflow;

    modport master (
        output start, close, in_valid, np, vip, vvip,
        input  in_ready, result, state, done, pass, overflow
    );

    modport slave (
        input  start, close, in_valid, np, vip, vvip,
        output in_ready, result, state, done, pass, overflow
    );
endinterface

// File: rtl/weighted_vote_tally.sv
// Session-based weighted ballot accumulator: 2-stage pipeline (weigh, then saturating add),
// with a frozen final tally, sticky overflow and a threshold verdict latched on entry to DONE.
module weighted_vote_tally #(
    parameter int unsigned NP_W    = 32,
    parameter int unsigned VIP_W   = 8,
    parameter int unsigned VVIP_W  = 1,
    parameter int unsigned NP_WT   = 1,
    parameter int unsigned VIP_WT  = 4,
    parameter int unsigned VVIP_WT = 16,
    parameter int unsigned RES_W   = 16,
    parameter int unsigned THRESH  = 100
) (
    input logic                  clk,
    input logic                  reset,
    weighted_vote_tally_if.slave bus
);
    localparam int unsigned BW = $clog2(NP_W * NP_WT + VIP_W * VIP_WT + VVIP_W * VVIP_WT + 1);
    // One bit wider than either operand so the sum can never wrap before the clamp check.
    localparam int unsigned SW = ((RES_W > BW) ? RES_W : BW) + 1;
    localparam logic [SW-1:0] RES_MAX = {{(SW - RES_W){1'b0}}, {RES_W{1'b1}}};

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StOpen  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_t;

    state_t           r_state;
    logic [BW-1:0]    r_weight;
    logic             r_s1_valid;
    logic [RES_W-1:0] r_result;
    logic             r_overflow;
    logic             r_in_ready;
    logic             r_done;
    logic             r_pass;

    logic [BW-1:0]    w_weight;
    logic [SW-1:0]    w_sum;
    logic             w_clamp;
    logic [RES_W-1:0] w_next_result;
    logic             w_next_pass;

    always_comb begin
        w_weight = '0;
        for (int i = 0; i < NP_W; i++) begin
            if (bus.np[i]) w_weight = w_weight + BW'(NP_WT);
        end
        for (int i = 0; i < VIP_W; i++) begin
            if (bus.vip[i]) w_weight = w_weight + BW'(VIP_WT);
        end
        for (int i = 0; i < VVIP_W; i++) begin
            if (bus.vvip[i]) w_weight = w_weight + BW'(VVIP_WT);
        end
    end

    always_comb begin
        w_sum         = SW'(r_result) + SW'(r_weight);
        w_clamp       = r_s1_valid && (w_sum > RES_MAX);
        w_next_result = r_result;
        if (r_s1_valid) w_next_result = w_clamp ? RES_MAX[RES_W-1:0] : w_sum[RES_W-1:0];
        w_next_pass   = (32'(w_next_result) >= THRESH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_weight   <= '0;
            r_s1_valid <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_in_ready <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            // Stage 2 runs every edge; session clears below override it.
            r_result   <= w_next_result;
            r_overflow <= r_overflow | w_clamp;
            r_s1_valid <= 1'b0;
            unique case (r_state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        r_state    <= StOpen;
                        r_result   <= '0;
                        r_overflow <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                    end
                end
                StOpen: begin
                    if (bus.start) begin
                        r_result   <= '0;
                        r_overflow <= 1'b0;
                    end else begin
                        if (bus.in_valid) begin
                            r_s1_valid <= 1'b1;
                            r_weight   <= w_weight;
                        end
                        if (bus.close) begin
                            r_state    <= StDrain;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                StDrain: begin
                    r_state <= StDone;
                    r_done  <= 1'b1;
                    r_pass  <= w_next_pass;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.result   = r_result;
    assign bus.state    = r_state;
    assign bus.done     = r_done;
    assign bus.pass     = r_pass;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_weighted_vote_tally.sv
// Directed bench: three tally instances (default, RES_W=8, THRESH=8) share one stimulus stream.
module tb_weighted_vote_tally;
    logic        clk;
    logic        reset;
    logic        start;
    logic        close;
    logic        in_valid;
    logic [31:0] np;
    logic [7:0]  vip;
    logic [0:0]  vvip;

    int n_cmp;
    int n_bad;

    weighted_vote_tally_if #(.RES_W(16)) if_a ();
    weighted_vote_tally_if #(.RES_W(8))  if_b ();
    weighted_vote_tally_if #(.RES_W(16)) if_c ();

    assign if_a.start = start;  assign if_a.close = close;  assign if_a.in_valid = in_valid;
    assign if_a.np    = np;     assign if_a.vip   = vip;    assign if_a.vvip     = vvip;
    assign if_b.start = start;  assign if_b.close = close;  assign if_b.in_valid = in_valid;
    assign if_b.np    = np;     assign if_b.vip   = vip;    assign if_b.vvip     = vvip;
    assign if_c.start = start;  assign if_c.close = close;  assign if_c.in_valid = in_valid;
    assign if_c.np    = np;     assign if_c.vip   = vip;    assign if_c.vvip     = vvip;

    weighted_vote_tally dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    weighted_vote_tally #(.RES_W(8)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
    weighted_vote_tally #(.THRESH(8)) dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic s, input logic c, input logic v, input logic [31:0] n,
                        input logic [7:0] vp, input logic vv);
        start = s; close = c; in_valid = v; np = n; vip = vp; vvip = vv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        start = 0; close = 0; in_valid = 0; np = '0; vip = '0; vvip = '0;
        #2;
        chk("rst_state", 32'(if_a.state), 0);
        chk("rst_result", 32'(if_a.result), 0);
        chk("rst_done", 32'(if_a.done), 0);
        chk("rst_pass", 32'(if_a.pass), 0);
        chk("rst_ovf", 32'(if_a.overflow), 0);
        chk("rst_ready", 32'(if_a.in_ready), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Ballot in IDLE is ignored
        step(0, 0, 1, 32'hFFFFFFFF, 8'hFF, 1);
        chk("idle_state", 32'(if_a.state), 0);
        chk("idle_result", 32'(if_a.result), 0);
        chk("idle_ready", 32'(if_a.in_ready), 0);

        // Single full ballot, weight 80
        step(1, 0, 0, 0, 0, 0);
        chk("t1_open", 32'(if_a.state), 1);
        chk("t1_ready", 32'(if_a.in_ready), 1);
        step(0, 0, 1, 32'hFFFFFFFF, 8'hFF, 1);
        chk("t1_lat", 32'(if_a.result), 0);
        step(0, 1, 0, 0, 0, 0);
        chk("t1_res", 32'(if_a.result), 80);
        chk("t1_drain", 32'(if_a.state), 2);
        chk("t1_ready0", 32'(if_a.in_ready), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t1_done_st", 32'(if_a.state), 3);
        chk("t1_done", 32'(if_a.done), 1);
        chk("t1_pass_a", 32'(if_a.pass), 0);
        chk("t1_pass_c", 32'(if_c.pass), 1);
        chk("t1_final", 32'(if_a.result), 80);

        // Back-to-back, close with second ballot
        step(1, 0, 0, 0, 0, 0);
        chk("t2_clr", 32'(if_a.result), 0);
        chk("t2_open", 32'(if_a.state), 1);
        step(0, 0, 1, 32'hFFFFFFFF, 8'hFF, 1);
        step(0, 1, 1, 32'hFFFFFFFF, 8'hFF, 1);
        chk("t2_mid", 32'(if_a.result), 80);
        chk("t2_drain", 32'(if_a.state), 2);
        step(0, 0, 0, 0, 0, 0);
        chk("t2_res", 32'(if_a.result), 160);
        chk("t2_pass", 32'(if_a.pass), 1);
        chk("t2_ovf", 32'(if_a.overflow), 0);
        chk("t2_done", 32'(if_a.state), 3);

        // Four full ballots: saturates at 255 for RES_W=8
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFFFFFF, 8'hFF, 1);
        step(0, 0, 1, 32'hFFFFFFFF, 8'hFF, 1);
        step(0, 0, 1, 32'hFFFFFFFF, 8'hFF, 1);
        step(0, 1, 1, 32'hFFFFFFFF, 8'hFF, 1);
        chk("t3_mid", 32'(if_a.result), 240);
        step(0, 0, 0, 0, 0, 0);
        chk("t3_sat", 32'(if_b.result), 255);
        chk("t3_ovf_b", 32'(if_b.overflow), 1);
        chk("t3_pass_b", 32'(if_b.pass), 1);
        chk("t3_done_b", 32'(if_b.done), 1);
        chk("t3_res_a", 32'(if_a.result), 320);
        chk("t3_ovf_a", 32'(if_a.overflow), 0);
        step(1, 0, 0, 0, 0, 0);
        chk("t3_clr_res", 32'(if_b.result), 0);
        chk("t3_clr_ovf", 32'(if_b.overflow), 0);
        chk("t3_clr_st", 32'(if_b.state), 1);
        chk("t3_clr_pass", 32'(if_b.pass), 0);

        // Weight 8 with THRESH=8: equality passes
        step(0, 1, 1, 32'h0000000F, 8'h01, 0);
        chk("t4_drain", 32'(if_c.state), 2);
        chk("t4_lat", 32'(if_c.result), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t4_res", 32'(if_c.result), 8);
        chk("t4_pass_c", 32'(if_c.pass), 1);
        chk("t4_pass_a", 32'(if_a.pass), 0);

        // Restart while a ballot sits in stage 1
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFFFFFF, 8'hFF, 1);
        chk("t5_s1", 32'(if_a.result), 0);
        step(1, 0, 1, 32'hFFFFFFFF, 8'hFF, 1);
        chk("t5_rst_res", 32'(if_a.result), 0);
        chk("t5_rst_st", 32'(if_a.state), 1);
        step(0, 1, 1, 32'h0000001F, 8'h00, 0);
        chk("t5_drain_res", 32'(if_a.result), 0);
        chk("t5_drain", 32'(if_a.state), 2);
        step(0, 0, 0, 0, 0, 0);
        chk("t5_res", 32'(if_a.result), 5);
        chk("t5_ovf", 32'(if_a.overflow), 0);

        // Ballot and close in DONE are ignored
        step(0, 0, 1, 32'hFFFFFFFF, 8'hFF, 1);
        chk("t6_res", 32'(if_a.result), 5);
        chk("t6_done", 32'(if_a.done), 1);
        step(0, 1, 0, 0, 0, 0);
        chk("t6_state", 32'(if_a.state), 3);
        chk("t6_res2", 32'(if_a.result), 5);

        // Asynchronous reset mid-session
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFFFFFF, 8'hFF, 1);
        step(0, 0, 1, 32'hFFFFFFFF, 8'hFF, 1);
        chk("t7_pre", 32'(if_a.result), 80);
        in_valid = 0;
        #3 reset = 1'b1;
        #1;
        chk("t7_state", 32'(if_a.state), 0);
        chk("t7_result", 32'(if_a.result), 0);
        chk("t7_ready", 32'(if_a.in_ready), 0);
        chk("t7_done", 32'(if_a.done), 0);
        chk("t7_pass", 32'(if_a.pass), 0);
        chk("t7_ovf", 32'(if_a.overflow), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        chk("t7_flushed", 32'(if_a.result), 0);
        chk("t7_idle", 32'(if_a.state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
